// File: rtl/pipelined_cond_sum_adder_pkg.sv
// Shared definitions for the conditional-sum adder: mode encoding, pair-record layout, clog2 helper.
package pipelined_cond_sum_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // A pair record is N_FIELDS words of WIDTH bits; field f lives at [f*WIDTH +: WIDTH].
    localparam int F_SUM0   = 0;
    localparam int F_SUM1   = 1;
    localparam int F_CY0    = 2;
    localparam int F_CY1    = 3;
    localparam int N_FIELDS = 4;

    function automatic int csaClog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/csa_merge_stage.sv
// Combinational merge of adjacent conditional-sum blocks of size BLK into blocks of 2*BLK.
// Latency: 0 (pure combinational). Backpressure: none, the owning pipeline stalls around it.
// Every bit carries the carry pair of its own block, so each bit can be merged independently.
module csa_merge_stage
    import pipelined_cond_sum_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 1
) (
    input  logic [N_FIELDS*WIDTH-1:0] recIn,
    output logic [N_FIELDS*WIDTH-1:0] recOut
);

    logic [WIDTH-1:0] s0, s1, k0, k1;
    logic [WIDTH-1:0] s0n, s1n, k0n, k1n;

    assign s0 = recIn[F_SUM0*WIDTH +: WIDTH];
    assign s1 = recIn[F_SUM1*WIDTH +: WIDTH];
    assign k0 = recIn[F_CY0*WIDTH +: WIDTH];
    assign k1 = recIn[F_CY1*WIDTH +: WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i / BLK) % 2) == 0) begin : g_lo
            // Lower half keeps its sums; its carry becomes the merged block's carry-out.
            assign s0n[i] = s0[i];
            assign s1n[i] = s1[i];
            assign k0n[i] = k0[i] ? k1[i+BLK] : k0[i+BLK];
            assign k1n[i] = k1[i] ? k1[i+BLK] : k0[i+BLK];
        end else begin : g_hi
            assign s0n[i] = k0[i-BLK] ? s1[i] : s0[i];
            assign s1n[i] = k1[i-BLK] ? s1[i] : s0[i];
            assign k0n[i] = k0[i-BLK] ? k1[i] : k0[i];
            assign k1n[i] = k1[i-BLK] ? k1[i] : k0[i];
        end
    end

    assign recOut[F_SUM0*WIDTH +: WIDTH] = s0n;
    assign recOut[F_SUM1*WIDTH +: WIDTH] = s1n;
    assign recOut[F_CY0*WIDTH +: WIDTH]  = k0n;
    assign recOut[F_CY1*WIDTH +: WIDTH]  = k1n;

endmodule

// File: rtl/pipelined_cond_sum_adder.sv
// Pipelined conditional-sum adder/subtractor with carry-out and signed overflow.
// Latency: LEVELS+1 cycles from accept to out_valid. Backpressure: global stall, in_ready = !out_valid | out_ready.
// Stage 0 forms per-bit pairs (bit 0 resolved with the effective carry-in); stages 1..LEVELS merge.
module pipelined_cond_sum_adder
    import pipelined_cond_sum_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c0,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cOut,
    output logic             ovf
);

    localparam int LEVELS = csaClog2(WIDTH);
    localparam int RW     = N_FIELDS * WIDTH;

    logic [RW-1:0]    recQ     [0:LEVELS];
    logic [RW-1:0]    mergeOut [1:LEVELS];
    logic [LEVELS:0]  vldQ;
    logic [LEVELS:0]  xMsbQ;
    logic [LEVELS:0]  yMsbQ;
    logic [RW-1:0]    recIn0;
    logic [WIDTH-1:0] yb, pBits, s0, s1, k0, k1;
    logic             cinEff;
    logic             adv;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        yb     = (sub == MODE_SUB) ? ~y : y;
        cinEff = (sub == MODE_SUB) ? 1'b1 : c0;
        pBits  = x ^ yb;
        s0     = pBits;
        s1     = ~pBits;
        k0     = x & yb;
        k1     = x | yb;
        s0[0]  = pBits[0] ^ cinEff;
        s1[0]  = pBits[0] ^ cinEff;
        k0[0]  = (x[0] & yb[0]) | (pBits[0] & cinEff);
        k1[0]  = (x[0] & yb[0]) | (pBits[0] & cinEff);
        recIn0 = '0;
        recIn0[F_SUM0*WIDTH +: WIDTH] = s0;
        recIn0[F_SUM1*WIDTH +: WIDTH] = s1;
        recIn0[F_CY0*WIDTH +: WIDTH]  = k0;
        recIn0[F_CY1*WIDTH +: WIDTH]  = k1;
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        csa_merge_stage #(
            .WIDTH (WIDTH),
            .BLK   (1 << (k - 1))
        ) u_merge (
            .recIn  (recQ[k-1]),
            .recOut (mergeOut[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vldQ  <= '0;
            xMsbQ <= '0;
            yMsbQ <= '0;
            for (int k = 0; k <= LEVELS; k++) recQ[k] <= '0;
        end else if (adv) begin
            // Data registers advance even for bubbles; only the valid bit marks real beats.
            vldQ    <= {vldQ[LEVELS-1:0], in_valid};
            xMsbQ   <= {xMsbQ[LEVELS-1:0], x[WIDTH-1]};
            yMsbQ   <= {yMsbQ[LEVELS-1:0], yb[WIDTH-1]};
            recQ[0] <= recIn0;
            for (int k = 1; k <= LEVELS; k++) recQ[k] <= mergeOut[k];
        end
    end

    // The final block spans the whole word, so sum0/cy0 are already the resolved values.
    assign out_valid = vldQ[LEVELS];
    assign S         = recQ[LEVELS][F_SUM0*WIDTH +: WIDTH];
    assign cOut      = recQ[LEVELS][F_CY0*WIDTH + WIDTH - 1];
    assign ovf       = (xMsbQ[LEVELS] == yMsbQ[LEVELS]) & (S[WIDTH-1] != xMsbQ[LEVELS]);

    logic unusedRecBits;
    assign unusedRecBits = ^{recQ[LEVELS][F_SUM1*WIDTH +: WIDTH],
                             recQ[LEVELS][F_CY0*WIDTH +: WIDTH-1],
                             recQ[LEVELS][F_CY1*WIDTH +: WIDTH]};

endmodule

// File: tb/tb_pipelined_cond_sum_adder.sv
// Directed bench for the 8-bit build of the pipelined conditional-sum adder.
module tb_pipelined_cond_sum_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x, y;
    logic       c0, sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] S;
    logic       cOut, ovf;

    int checks = 0;
    int errors = 0;

    pipelined_cond_sum_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .c0        (c0),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .cOut      (cOut),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {S, cOut, ovf} computed from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb);
        logic [7:0] bb;
        logic [8:0] t;
        logic       ov;
        bb = sb ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {8'd0, (sb ? 1'b1 : ci)};
        ov = (a[7] == bb[7]) && (t[7] != a[7]);
        return {t[7:0], t[8], ov};
    endfunction

    task automatic runOne(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                          input logic cv, input logic sv,
                          input int expS, input int expC, input int expO);
        int lat;
        @(negedge clk);
        x = xv; y = yv; c0 = cv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, lat, 4);
        check({tag, ".S"}, 32'(S), expS);
        check({tag, ".cOut"}, 32'(cOut), expC);
        check({tag, ".ovf"}, 32'(ovf), expO);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sx [6];
        logic [7:0] sy [6];
        logic       sc [6];
        logic       ss [6];
        logic [9:0] sexp [6];
        logic [9:0] expQ [$];
        logic [7:0] rx, ry;
        logic       rc, rs;
        int sent, got, leak;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; c0 = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 0);
        check("rst.S", 32'(S), 0);
        check("rst.cOut", 32'(cOut), 0);
        check("rst.ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 1);

        runOne("add12_5",      8'd12,  8'd5,   1'b0, 1'b0, 17,  0, 0);
        runOne("add12_5_c",    8'd12,  8'd5,   1'b1, 1'b0, 18,  0, 0);
        runOne("wrap255_1",    8'd255, 8'd1,   1'b0, 1'b0, 0,   1, 0);
        runOne("wrap255_1_c",  8'd255, 8'd1,   1'b1, 1'b0, 1,   1, 0);
        runOne("f0_0f_c",      8'hF0,  8'h0F,  1'b1, 1'b0, 0,   1, 0);
        runOne("sub5_12",      8'd5,   8'd12,  1'b0, 1'b1, 249, 0, 0);
        runOne("sub12_5",      8'd12,  8'd5,   1'b0, 1'b1, 7,   1, 0);
        runOne("sub12_5_cign", 8'd12,  8'd5,   1'b1, 1'b1, 7,   1, 0);
        runOne("sub80_1",      8'h80,  8'd1,   1'b0, 1'b1, 127, 1, 1);
        runOne("ovf127_1",     8'd127, 8'd1,   1'b0, 1'b0, 128, 0, 1);
        runOne("ovf80_80",     8'h80,  8'h80,  1'b0, 1'b0, 0,   1, 1);

        // Six back-to-back beats with a three-cycle downstream stall mid-stream.
        sx[0] = 8'd1;   sy[0] = 8'd2;   sc[0] = 1'b0; ss[0] = 1'b0; sexp[0] = {8'd3,   1'b0, 1'b0};
        sx[1] = 8'd100; sy[1] = 8'd100; sc[1] = 1'b0; ss[1] = 1'b0; sexp[1] = {8'd200, 1'b0, 1'b1};
        sx[2] = 8'd200; sy[2] = 8'd50;  sc[2] = 1'b0; ss[2] = 1'b1; sexp[2] = {8'd150, 1'b1, 1'b0};
        sx[3] = 8'hAA;  sy[3] = 8'h55;  sc[3] = 1'b1; ss[3] = 1'b0; sexp[3] = {8'd0,   1'b1, 1'b0};
        sx[4] = 8'd3;   sy[4] = 8'd3;   sc[4] = 1'b0; ss[4] = 1'b1; sexp[4] = {8'd0,   1'b1, 1'b0};
        sx[5] = 8'h7F;  sy[5] = 8'h7F;  sc[5] = 1'b1; ss[5] = 1'b0; sexp[5] = {8'hFF,  1'b0, 1'b1};
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c < 8);
            #1;
            if (out_valid) begin
                check("stream.data", 32'({S, cOut, ovf}), 32'(sexp[got]));
                if (!out_ready) check("stream.stall_in_ready", 32'(in_ready), 0);
                else got++;
            end
            if (sent < 6) begin
                x = sx[sent]; y = sy[sent]; c0 = sc[sent]; sub = ss[sent];
                in_valid = 1'b1;
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream.count", got, 6);

        // Reset with three beats in flight: none of them may surface afterwards.
        @(negedge clk);
        x = 8'd1; y = 8'd1; c0 = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        x = 8'd2;
        @(negedge clk);
        x = 8'd3;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.out_valid", 32'(out_valid), 0);
        check("midrst.S", 32'(S), 0);
        check("midrst.in_ready", 32'(in_ready), 1);
        leak = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) leak++;
        end
        check("midrst.no_stale", leak, 0);

        // Random stream with random bubbles and backpressure against the arithmetic model.
        sent = 0; got = 0;
        for (int c = 0; c < 3000 && got < 300; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) check("rand.spurious", 32'(out_valid), 0);
                else check("rand.data", 32'({S, cOut, ovf}), 32'(expQ.pop_front()));
                got++;
            end
            if (sent < 300 && $urandom_range(0, 4) != 0) begin
                rx = 8'($urandom); ry = 8'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
                x = rx; y = ry; c0 = rc; sub = rs; in_valid = 1'b1;
                if (in_ready) begin
                    expQ.push_back(model(rx, ry, rc, rs));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("rand.count", got, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
